nexys2_keypad_scanner: RTL
==========================

Name: nexys2_keypad_scanner

Overview:
- Input-side counterpart of the board's multiplexed hex display driver.
- Scans a 4x4 hex keypad (Pmod KYPD style) by driving one column low at a time and reading four pulled-up row lines.
- Debounces each press and decodes row/column to a 4-bit hex code.
- Presents the code to the control logic through a valid/ack handshake, so keypad entries can feed the same nibble datapath that drives the display.

Parameters:
- DWELL_W, 16: column dwell is 2^DWELL_W clocks; minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-frame results needed to accept a press or a release; range 1-15.
- REPEAT_DELAY_SCANS, 100: frames held before the first auto-repeat. Used only with NEXYS2_KEYPAD_REPEAT_EN.
- REPEAT_RATE_SCANS, 25: frames between subsequent repeats. Used only with NEXYS2_KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  keypad column drive, active-low, exactly one bit low
- key_code  out  4  hex code of last accepted key
- key_valid  out  1  high while key_code holds an unacknowledged key
- key_ack  in  1  consumer acknowledge, sampled on clk
- key_down  out  1  level; high while the debounced key is held
- overrun  out  1  sticky; a key was accepted while key_valid was still high

Behaviour:
- Reset state:
  - col_out=4'b1110; key_code=0; key_valid=0; key_down=0; overrun=0.
  - Dwell counter, column index, debounce counter and repeat counter all 0; FSM in IDLE.
  - Reset mid-scan or mid-debounce restarts from column 0 with no event emitted.
- Synchronizer: row_in passes through 2 flops before any use.
- Scan timing:
  - The dwell counter increments every clk.
  - When the counter is all ones, the synchronized rows are sampled for the current column. On the next clk the column index advances (wraps 3->0) and col_out updates to ~(1<<index).
  - One frame is columns 0..3, i.e. 4*2^DWELL_W clocks.
- Frame result, evaluated on the cycle after the column-3 sample, counting low row bits across all 4 samples:
  - NONE: 0 low bits.
  - SINGLE(code): exactly 1 low bit.
  - MULTI: 2 or more low bits.
- Key map, indexed [row][col], columns 0..3 left to right:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Debounce FSM, states IDLE, PRESS_DB, PRESSED, RELEASE_DB:
  - IDLE:
    - SINGLE(c): candidate=c, cnt=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI: stay.
  - PRESS_DB:
    - SINGLE equal to candidate: cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - SINGLE different from candidate: candidate=new code, cnt=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE_DB.
    - SINGLE or MULTI: stay. A second key never generates an event.
  - RELEASE_DB:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, key_down=0 and go to IDLE.
    - SINGLE or MULTI: go back to PRESSED.
- Accept action: key_code=candidate, key_valid=1, key_down=1. All take effect in the same clk as the FSM transition.
- Handshake:
  - key_valid stays high until key_ack is sampled high; key_ack clears key_valid and overrun next clk.
  - key_ack while key_valid=0 is ignored.
  - Accept with key_valid=1 and key_ack=0: key_code is overwritten, key_valid stays 1, overrun=1.
  - Accept and key_ack in the same clk: key_valid=1, new code, overrun=0.
- Latency, rows stable low from start of frame: accept occurs DEBOUNCE_SCANS frames after the first frame showing the key, plus 1 clk after frame end.

Optional Feature:
- Macro: NEXYS2_KEYPAD_REPEAT_EN.
- Defined:
  - While in PRESSED, a frame counter runs.
  - After REPEAT_DELAY_SCANS frames it performs an accept (same code), then again every REPEAT_RATE_SCANS frames.
  - Leaving PRESSED (into RELEASE_DB) clears the counter, and the counter restarts from 0 on return to PRESSED.
  - Repeat accepts obey the same overrun rules.
- Undefined: exactly one accept per press; repeat parameters are unused and no repeat counter is synthesized.

Test Plan (DWELL_W=2, DEBOUNCE_SCANS=2, frame=16 clks):
1. Reset: assert rst 3 clks -> col_out=1110, key_valid=0, key_code=0, key_down=0. Release rst -> col_out cycles 1110,1101,1011,0111 every 4 clks.
2. Hold key "5" (row1 low only while col1 driven) for 4 frames -> key_valid=1, key_code=4'h5, key_down=1 at end of frame 2 +1 clk. Pulse key_ack -> key_valid=0 next clk. Release for 2 frames -> key_down=0.
3. Bounce: key "D" present 1 frame, absent 1 frame, present 2 frames -> exactly one accept, code 4'hD, no accept after the first frame.
4. Multi-key: "1" and "A" held together -> no accept, key_valid stays 0. While "3" is PRESSED, add "7" -> no new event; release both -> key_down falls after 2 NONE frames.
5. Overrun: accept "2", no ack, then release and press "E" -> key_code=4'hE, overrun=1. key_ack -> key_valid=0, overrun=0. Also check ack coincident with accept -> key_valid=1, overrun=0.
6. Repeat (macro on, REPEAT_DELAY_SCANS=3, REPEAT_RATE_SCANS=2, ack each event): hold "0" for 10 frames -> accepts at frames 2, 5, 7, 9. Macro off -> one accept only.

Source files
------------

// File: rtl/nexys2_keypad_scanner.sv
// nexys2_keypad_scanner
//   Scans a 4x4 hex keypad (Pmod KYPD style): drives one column low at a time,
//   samples the four pulled-up rows, debounces whole-frame results and hands the
//   decoded hex code to the control logic through a valid/ack handshake.
//
//   Optional feature: define NEXYS2_KEYPAD_REPEAT_EN to enable auto-repeat while
//   a key stays held (REPEAT_DELAY_SCANS frames to the first repeat, then one
//   every REPEAT_RATE_SCANS frames). Without it each press yields one accept.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    keypad column drive, active-low, exactly one bit low
//   key_code   hex code of the last accepted key
//   key_valid  high while key_code holds an unacknowledged key
//   key_ack    consumer acknowledge, sampled on clk
//   key_down   high while the debounced key is held
//   overrun    sticky; a key was accepted while key_valid was still high
module nexys2_keypad_scanner #(
    parameter int unsigned DWELL_W            = 16,
    parameter int unsigned DEBOUNCE_SCANS     = 4,
    parameter int unsigned REPEAT_DELAY_SCANS = 100,
    parameter int unsigned REPEAT_RATE_SCANS  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int unsigned NLINE = 4;
    localparam int unsigned DB_W  = 4;
    localparam int unsigned LCN_W = 5;
    localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    // Elaboration-time guard on the supported parameter ranges
    if (DWELL_W < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_bad_config
        $error("nexys2_keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // Row/column position to hex legend of the keypad
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_max;
    logic [1:0]         col_idx;
    logic [1:0]         col_idx_inc;
    logic [3:0][3:0]    low_smp;     // [col][row], 1 = row seen low
    logic               frame_done;
    logic [LCN_W-1:0]   low_cnt;
    logic [3:0]         low_code;
    logic               frame_none;
    logic               frame_single;

    state_t             state;
    state_t             state_nxt;
    logic [DB_W-1:0]    db_cnt;
    logic [DB_W-1:0]    db_cnt_nxt;
    logic [DB_W-1:0]    db_inc;
    logic [3:0]         cand;
    logic [3:0]         cand_nxt;
    logic [3:0]         code_nxt;
    logic               valid_nxt;
    logic               down_nxt;
    logic               ovr_nxt;
    logic               accept;
    logic [3:0]         accept_code;

`ifdef NEXYS2_KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                                      REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY_SCANS);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE_SCANS);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic [REP_W-1:0] rep_inc;
    logic             rep_armed;
    logic             rep_armed_nxt;
`endif

    assign dwell_max   = &dwell_cnt;
    assign col_idx_inc = col_idx + 2'd1;
    assign db_inc      = db_cnt + DB_ONE;

    // Row synchronizer, column dwell timer and per-column row capture
    always_ff @(posedge clk) begin : scan_reg
        if (rst) begin
            row_meta   <= '1;
            row_sync   <= '1;
            dwell_cnt  <= '0;
            col_idx    <= '0;
            col_out    <= 4'b1110;
            low_smp    <= '0;
            frame_done <= 1'b0;
        end else begin
            row_meta   <= row_in;
            row_sync   <= row_meta;
            dwell_cnt  <= dwell_cnt + DWELL_W'(1);
            frame_done <= dwell_max && (col_idx == 2'd3);
            if (dwell_max) begin
                low_smp[col_idx] <= ~row_sync;
                col_idx          <= col_idx_inc;
                col_out          <= ~(4'b0001 << col_idx_inc);
            end
        end
    end

    // Frame classification: number of low row bits and code of the last one found
    always_comb begin : frame_classify
        low_cnt  = '0;
        low_code = '0;
        for (int c = 0; c < NLINE; c++) begin
            for (int r = 0; r < NLINE; r++) begin
                if (low_smp[c][r]) begin
                    low_cnt  = low_cnt + LCN_W'(1);
                    low_code = key_map(2'(r), 2'(c));
                end
            end
        end
    end

    assign frame_none   = (low_cnt == '0);
    assign frame_single = (low_cnt == LCN_W'(1));

    // Debounce FSM and handshake registers
    always_ff @(posedge clk) begin : fsm_reg
        if (rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
`ifdef NEXYS2_KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            cand      <= cand_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_down  <= down_nxt;
            overrun   <= ovr_nxt;
`ifdef NEXYS2_KEYPAD_REPEAT_EN
            rep_cnt   <= rep_cnt_nxt;
            rep_armed <= rep_armed_nxt;
`endif
        end
    end

    // Next-state, accept decision and handshake update
    always_comb begin : fsm_next
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        cand_nxt    = cand;
        down_nxt    = key_down;
        code_nxt    = key_code;
        valid_nxt   = key_valid;
        ovr_nxt     = overrun;
        accept      = 1'b0;
        accept_code = cand;
`ifdef NEXYS2_KEYPAD_REPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
        rep_inc       = rep_cnt + REP_W'(1);
`endif

        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_nxt = low_code;
                        if (DB_LIM == DB_ONE) begin
                            accept      = 1'b1;
                            accept_code = low_code;
                            state_nxt   = PRESSED;
                        end else begin
                            db_cnt_nxt = DB_ONE;
                            state_nxt  = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_single && (low_code == cand)) begin
                        if (db_inc == DB_LIM) begin
                            accept    = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            db_cnt_nxt = db_inc;
                        end
                    end else if (frame_single) begin
                        // A different single key restarts the count on the new code
                        cand_nxt   = low_code;
                        db_cnt_nxt = DB_ONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_none) begin
                        if (DB_LIM == DB_ONE) begin
                            down_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            db_cnt_nxt = DB_ONE;
                            state_nxt  = RELEASE_DB;
                        end
`ifdef NEXYS2_KEYPAD_REPEAT_EN
                        rep_cnt_nxt   = '0;
                        rep_armed_nxt = 1'b0;
`endif
                    end else begin
`ifdef NEXYS2_KEYPAD_REPEAT_EN
                        // First repeat after the delay, later ones at the rate
                        if (rep_inc == (rep_armed ? REP_RATE : REP_DELAY)) begin
                            accept        = 1'b1;
                            rep_cnt_nxt   = '0;
                            rep_armed_nxt = 1'b1;
                        end else begin
                            rep_cnt_nxt = rep_inc;
                        end
`endif
                    end
                end
                RELEASE_DB: begin
                    if (frame_none) begin
                        if (db_inc == DB_LIM) begin
                            down_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            db_cnt_nxt = db_inc;
                        end
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (accept) begin
            code_nxt  = accept_code;
            valid_nxt = 1'b1;
            down_nxt  = 1'b1;
            if (key_valid && !key_ack) begin
                ovr_nxt = 1'b1;
            end else if (key_ack) begin
                ovr_nxt = 1'b0;
            end
        end else if (key_ack && key_valid) begin
            valid_nxt = 1'b0;
            ovr_nxt   = 1'b0;
        end
    end

endmodule
